// File: rtl/rv_pkg.sv
// Shared definitions for the RV32I single-cycle core: opcodes, ALU operations, select codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB
  } alu_op_t;

  // Source of the value written back to rd
  typedef enum logic [1:0] {
    WB_ALU,
    WB_PC4,
    WB_MEM
  } wb_sel_t;

  // Source of the next PC
  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_JAL,
    PC_JALR,
    PC_HOLD
  } pc_sel_t;

endpackage

// File: rtl/rv_alu.sv
// 32-bit RV32I ALU with compare flags for branch resolution.
// Latency: purely combinational.
// Backpressure: none; result valid whenever inputs are.
module rv_alu
  import rv_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_t     alu_op_i,
  output logic [31:0] y_o,
  output logic        zero_o,
  output logic        lt_o,
  output logic        ltu_o
);

  logic lt;
  logic ltu;

  assign lt     = $signed(a_i) < $signed(b_i);
  assign ltu    = a_i < b_i;
  assign lt_o   = lt;
  assign ltu_o  = ltu;
  assign zero_o = (y_o == 32'd0);

  // Operation select; shift amounts use only the low five bits of b
  always_comb begin
    y_o = 32'd0;
    case (alu_op_i)
      ALU_ADD:   y_o = a_i + b_i;
      ALU_SUB:   y_o = a_i - b_i;
      ALU_SLL:   y_o = a_i << b_i[4:0];
      ALU_SLT:   y_o = {31'd0, lt};
      ALU_SLTU:  y_o = {31'd0, ltu};
      ALU_XOR:   y_o = a_i ^ b_i;
      ALU_SRL:   y_o = a_i >> b_i[4:0];
      ALU_SRA:   y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_OR:    y_o = a_i | b_i;
      ALU_AND:   y_o = a_i & b_i;
      ALU_PASSB: y_o = b_i;
      default:   y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core with internal word-addressed ROM/RAM; optional halt on ECALL/EBREAK via RV_HALT_EN.
// Latency: one instruction retires per clk; fetch/decode/ALU/DMEM read are combinational.
// Backpressure: none; only a halt (RV_HALT_EN builds) freezes PC and suppresses writes until reset.
module rv32i_single_cycle_core
  import rv_pkg::*;
#(
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_o,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data,
  output logic        halted_o
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  logic [31:0] rom_mem [IMEM_WORDS];
  logic [31:0] dmem_q  [DMEM_WORDS];
  logic [31:0] rf_q    [32];

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic        halted_q;

  logic [31:0] instr;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] alu_a, alu_b, alu_y;
  alu_op_t     alu_op;
  logic        alu_zero, alu_lt, alu_ltu;
  logic        rd_we, dmem_we, br_taken;
  wb_sel_t     wb_sel;
  pc_sel_t     pc_sel;
  logic [31:0] wb_data, dmem_rdata;
`ifdef RV_HALT_EN
  logic        halt_req;
`endif

  // ROM image: every word defaults to NOP
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) rom_mem[i] = NOP;
  end

  assign pc_plus4 = pc_q + 32'd4;
  assign instr    = rom_mem[pc_q[IW+1:2]];
  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7   = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Register reads see pre-edge state, so a same-cycle write is not forwarded
  assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
  assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : rf_q[dbg_sel];

  // Decode: choose ALU operands/op, writeback source, PC source; unsupported encodings fall through as NOP
  always_comb begin
    alu_a   = rs1_val;
    alu_b   = rs2_val;
    alu_op  = ALU_ADD;
    rd_we   = 1'b0;
    dmem_we = 1'b0;
    wb_sel  = WB_ALU;
    pc_sel  = PC_SEQ;
`ifdef RV_HALT_EN
    halt_req = 1'b0;
`endif
    case (opcode)
      LUI: begin
        alu_op = ALU_PASSB;
        alu_b  = imm_u;
        rd_we  = 1'b1;
      end
      AUIPC: begin
        alu_a = pc_q;
        alu_b = imm_u;
        rd_we = 1'b1;
      end
      JAL: begin
        rd_we  = 1'b1;
        wb_sel = WB_PC4;
        pc_sel = PC_JAL;
      end
      JALR: begin
        if (funct3 == 3'b000) begin
          alu_b  = imm_i;
          rd_we  = 1'b1;
          wb_sel = WB_PC4;
          pc_sel = PC_JALR;
        end
      end
      BRANCH: begin
        alu_op = ALU_SUB;
        if (funct3 != 3'b010 && funct3 != 3'b011) pc_sel = PC_BR;
      end
      LOAD: begin
        if (funct3 == 3'b010) begin
          alu_b  = imm_i;
          rd_we  = 1'b1;
          wb_sel = WB_MEM;
        end
      end
      STORE: begin
        if (funct3 == 3'b010) begin
          alu_b   = imm_s;
          dmem_we = 1'b1;
        end
      end
      OP_IMM: begin
        alu_b = imm_i;
        rd_we = 1'b1;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            alu_op = ALU_SLL;
            rd_we  = (funct7 == 7'b0000000);
          end
          default: begin
            alu_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            rd_we  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OP: begin
        rd_we = 1'b1;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_011: alu_op = ALU_SLTU;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0100000_101: alu_op = ALU_SRA;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_111: alu_op = ALU_AND;
          default:         rd_we  = 1'b0;
        endcase
      end
      SYSTEM: begin
`ifdef RV_HALT_EN
        if (instr == ECALL || instr == EBREAK) begin
          halt_req = 1'b1;
          pc_sel   = PC_HOLD;
        end
`endif
      end
      default: ;
    endcase
  end

  rv_alu u_alu (
    .a_i      (alu_a),
    .b_i      (alu_b),
    .alu_op_i (alu_op),
    .y_o      (alu_y),
    .zero_o   (alu_zero),
    .lt_o     (alu_lt),
    .ltu_o    (alu_ltu)
  );

  assign dmem_rdata = dmem_q[alu_y[DW+1:2]];

  // Branch condition from ALU compare flags
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = alu_zero;
      3'b001:  br_taken = !alu_zero;
      3'b100:  br_taken = alu_lt;
      3'b101:  br_taken = !alu_lt;
      3'b110:  br_taken = alu_ltu;
      3'b111:  br_taken = !alu_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Writeback data and next-PC selection
  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_PC4:  wb_data = pc_plus4;
      WB_MEM:  wb_data = dmem_rdata;
      default: wb_data = alu_y;
    endcase
    pc_d = pc_plus4;
    case (pc_sel)
      PC_BR:   if (br_taken) pc_d = pc_q + imm_b;
      PC_JAL:  pc_d = pc_q + imm_j;
      PC_JALR: pc_d = alu_y & ~32'd1;
      PC_HOLD: pc_d = pc_q;
      default: pc_d = pc_plus4;
    endcase
  end

  // Architectural state: PC and register file, frozen while halted
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (!halted_q) begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= wb_data;
    end
  end

  // Data RAM store port; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && !halted_q && dmem_we) dmem_q[alu_y[DW+1:2]] <= rs2_val;
  end

`ifdef RV_HALT_EN
  // Sticky halt flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset)         halted_q <= 1'b0;
    else if (halt_req) halted_q <= 1'b1;
  end
`else
  assign halted_q = 1'b0;
`endif

  assign pc_o     = pc_q;
  assign halted_o = halted_q;

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core: programs are written into the ROM through hierarchy.
// Latency: outputs sampled on the falling edge after each retiring rising edge.
// Backpressure: n/a.
module tb_rv32i_single_cycle_core;

  logic        clk;
  logic        reset;
  logic [31:0] pc_o;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic        halted_o;

  int vectors;
  int miscompares;

  rv32i_single_cycle_core #(
    .IMEM_WORDS (64),
    .DMEM_WORDS (64),
    .IMEM_FILE  ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_o     (pc_o),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .halted_o (halted_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    dut.rom_mem[idx] = w;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) dut.rom_mem[i] = 32'h0000_0013;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Hold reset over one rising edge; caller has already loaded the ROM
  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    dbg_sel     = 5'd0;
    #1;

    // ---------------- ALU program + reset checks ----------------
    clear_rom();
    put(0,  enc_i(12'd5,   5'd0, 3'b000, 5'd1, 7'h13));   // addi x1,x0,5
    put(1,  enc_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'h13));   // addi x2,x0,-3
    put(2,  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));      // add  x3,x1,x2
    put(3,  enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));      // sub  x4,x1,x2
    put(4,  enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5));      // slt  x5,x2,x1
    put(5,  enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6));      // sltu x6,x2,x1
    put(6,  enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd7));      // or   x7,x1,x2
    put(7,  enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd8));      // and  x8,x1,x2
    put(8,  enc_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd9));      // xor  x9,x1,x2
    put(9,  enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd10));     // sll  x10,x1,x1
    put(10, enc_i(12'hFFE, 5'd2, 3'b010, 5'd11, 7'h13));  // slti x11,x2,-2
    put(11, enc_i(12'hFFF, 5'd1, 3'b011, 5'd12, 7'h13));  // sltiu x12,x1,-1
    apply_reset();
    chk("reset_pc", pc_o, 32'h0);
    chk("reset_halted", {31'd0, halted_o}, 32'h0);
    for (int r = 0; r < 32; r++) chk_reg("reset_reg", r[4:0], 32'h0);
    reset = 1'b0;
    step(1); chk("pc_after_1", pc_o, 32'h4);
    step(1); chk("pc_after_2", pc_o, 32'h8);
    step(10);
    chk("alu_pc", pc_o, 32'h30);
    chk_reg("alu_x1", 5'd1, 32'h0000_0005);
    chk_reg("alu_x2", 5'd2, 32'hFFFF_FFFD);
    chk_reg("add_x3", 5'd3, 32'h0000_0002);
    chk_reg("sub_x4", 5'd4, 32'h0000_0008);
    chk_reg("slt_x5", 5'd5, 32'h0000_0001);
    chk_reg("sltu_x6", 5'd6, 32'h0000_0000);
    chk_reg("or_x7", 5'd7, 32'hFFFF_FFFD);
    chk_reg("and_x8", 5'd8, 32'h0000_0005);
    chk_reg("xor_x9", 5'd9, 32'hFFFF_FFF8);
    chk_reg("sll_x10", 5'd10, 32'h0000_00A0);
    chk_reg("slti_x11", 5'd11, 32'h0000_0001);
    chk_reg("sltiu_x12", 5'd12, 32'h0000_0001);

    // ---------------- Memory program ----------------
    reset = 1'b1;
    clear_rom();
    put(0, enc_i(12'h07F, 5'd0, 3'b000, 5'd1, 7'h13));    // addi x1,x0,0x7F
    put(1, enc_s(12'd8, 5'd1, 5'd0, 3'b010));             // sw x1,8(x0)
    put(2, enc_i(12'd8, 5'd0, 3'b010, 5'd2, 7'h03));      // lw x2,8(x0)
    put(3, enc_i(12'd9, 5'd0, 3'b000, 5'd0, 7'h13));      // addi x0,x0,9
    put(4, enc_i(12'h055, 5'd0, 3'b000, 5'd3, 7'h13));    // addi x3,x0,0x55
    put(5, enc_s(12'h108, 5'd3, 5'd0, 3'b010));           // sw x3,0x108(x0) -> wraps to word 2
    put(6, enc_i(12'd11, 5'd0, 3'b010, 5'd4, 7'h03));     // lw x4,11(x0) -> word 2
    put(7, enc_i(12'd8, 5'd0, 3'b000, 5'd5, 7'h03));      // lb x5,8(x0) -> NOP
    apply_reset();
    reset = 1'b0;
    step(8);
    chk("mem_pc", pc_o, 32'h20);
    chk_reg("lw_x2", 5'd2, 32'h0000_007F);
    chk_reg("x0_zero", 5'd0, 32'h0);
    chk_reg("wrap_lw_x4", 5'd4, 32'h0000_0055);
    chk_reg("lb_nop_x5", 5'd5, 32'h0);

    // ---------------- Control flow program ----------------
    reset = 1'b1;
    clear_rom();
    put(0,  enc_i(12'd1, 5'd0, 3'b000, 5'd2, 7'h13));     // 00 addi x2,x0,1
    put(1,  enc_b(13'd8, 5'd0, 5'd0, 3'b000));            // 04 beq x0,x0,+8
    put(2,  enc_i(12'd99, 5'd0, 3'b000, 5'd2, 7'h13));    // 08 addi x2,x0,99 (skipped)
    put(3,  enc_i(12'd7, 5'd0, 3'b000, 5'd3, 7'h13));     // 0C addi x3,x0,7
    put(4,  enc_j(21'd12, 5'd1));                         // 10 jal x1,+12
    put(5,  enc_i(12'd4, 5'd0, 3'b000, 5'd4, 7'h13));     // 14 addi x4,x0,4
    put(6,  enc_b(13'd12, 5'd2, 5'd0, 3'b110));           // 18 bltu x0,x2,+12 (taken)
    put(7,  enc_i(12'd0, 5'd1, 3'b000, 5'd0, 7'h67));     // 1C jalr x0,0(x1)
    put(9,  enc_b(13'd8, 5'd2, 5'd0, 3'b101));            // 24 bge x0,x2,+8 (not taken)
    put(10, enc_b(13'd0, 5'd0, 5'd0, 3'b000));            // 28 beq x0,x0,0
    apply_reset();
    reset = 1'b0;
    step(2); chk("beq_skip_pc", pc_o, 32'h0C);
    step(2); chk("jal_pc", pc_o, 32'h1C);
    chk_reg("jal_link_x1", 5'd1, 32'h14);
    step(1); chk("jalr_pc", pc_o, 32'h14);
    step(2); chk("bltu_taken_pc", pc_o, 32'h24);
    step(1); chk("bge_not_taken_pc", pc_o, 32'h28);
    step(1); chk("self_loop_pc", pc_o, 32'h28);
    chk_reg("skip_x2", 5'd2, 32'h1);
    chk_reg("cf_x3", 5'd3, 32'h7);
    chk_reg("cf_x4", 5'd4, 32'h4);

    // ---------------- Upper immediate / shift program ----------------
    reset = 1'b1;
    clear_rom();
    put(0, enc_u(20'h80000, 5'd1, 7'h37));                // lui x1,0x80000
    put(1, enc_i(12'h404, 5'd1, 3'b101, 5'd2, 7'h13));    // srai x2,x1,4
    put(2, enc_i(12'h004, 5'd1, 3'b101, 5'd3, 7'h13));    // srli x3,x1,4
    put(3, enc_u(20'h00001, 5'd4, 7'h17));                // auipc x4,1 at 0x0C
    put(4, enc_i(12'd31, 5'd0, 3'b000, 5'd6, 7'h13));     // addi x6,x0,31
    put(5, enc_r(7'h20, 5'd6, 5'd1, 3'b101, 5'd7));       // sra x7,x1,x6
    put(6, enc_r(7'h00, 5'd6, 5'd1, 3'b101, 5'd8));       // srl x8,x1,x6
    put(7, 32'h0000_000F);                                // fence -> NOP
    apply_reset();
    reset = 1'b0;
    step(8);
    chk("upper_pc", pc_o, 32'h20);
    chk_reg("lui_x1", 5'd1, 32'h8000_0000);
    chk_reg("srai_x2", 5'd2, 32'hF800_0000);
    chk_reg("srli_x3", 5'd3, 32'h0800_0000);
    chk_reg("auipc_x4", 5'd4, 32'h0000_100C);
    chk_reg("sra_x7", 5'd7, 32'hFFFF_FFFF);
    chk_reg("srl_x8", 5'd8, 32'h0000_0001);

    // ---------------- ECALL program ----------------
    reset = 1'b1;
    clear_rom();
    for (int i = 0; i < 8; i++) put(i, enc_i(12'd1, 5'd1, 3'b000, 5'd1, 7'h13));  // addi x1,x1,1
    put(8, 32'h0000_0073);                                // 20 ecall
    put(9, enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'h13));      // 24 addi x2,x0,5
    apply_reset();
    reset = 1'b0;
    step(8);
    chk("pre_ecall_pc", pc_o, 32'h20);
    chk_reg("pre_ecall_x1", 5'd1, 32'h8);
`ifdef RV_HALT_EN
    step(1);
    chk("halted_set", {31'd0, halted_o}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("halt_pc_frozen", pc_o, 32'h20);
      step(1);
    end
    chk_reg("halt_x2_unwritten", 5'd2, 32'h0);
    apply_reset();
    chk("halt_reset_pc", pc_o, 32'h0);
    chk("halt_reset_flag", {31'd0, halted_o}, 32'h0);
    reset = 1'b0;
`else
    step(1);
    chk("ecall_nop_pc", pc_o, 32'h24);
    chk("halted_tied_0", {31'd0, halted_o}, 32'h0);
    step(1);
    chk("post_ecall_pc", pc_o, 32'h28);
    chk_reg("post_ecall_x2", 5'd2, 32'h5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
